// File: rtl/hilo_div_ctrl_if.sv
// Bus between the control unit / divider and the HI/LO division stage.
// The master side is the control unit plus the per-edge divider.
interface hilo_div_ctrl_if;
    logic        start_div;
    logic        is_signed;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] wr_data;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        div_go;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start_div, is_signed, rs_val, rt_val,
        output hi_wr, lo_wr, wr_data, div_q, div_r,
        input  div_go, div_a, div_b, busy, done, div_zero,
        input  hi_out, lo_out
    );

    modport slave (
        input  start_div, is_signed, rs_val, rt_val,
        input  hi_wr, lo_wr, wr_data, div_q, div_r,
        output div_go, div_a, div_b, busy, done, div_zero,
        output hi_out, lo_out
    );
endinterface

// File: rtl/hilo_div_ctrl.sv
// Division sequencer: launches the divider, waits DIV_LAT cycles,
// sign-corrects the result and holds it in the HI/LO registers.
module hilo_div_ctrl #(
    parameter int DIV_LAT = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    hilo_div_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_COMMIT,
        S_ZERO
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(DIV_LAT - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_div_a;
    logic [31:0] r_div_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_go;
    logic        r_busy;
    logic        r_done;
    logic        r_zero;

    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_lo_fix;
    logic [31:0] w_hi_fix;

    // 0x80000000 negates to itself, which is the right unsigned magnitude
    assign w_rs_neg = bus.is_signed & bus.rs_val[31];
    assign w_rt_neg = bus.is_signed & bus.rt_val[31];
    assign w_mag_a  = w_rs_neg ? -bus.rs_val : bus.rs_val;
    assign w_mag_b  = w_rt_neg ? -bus.rt_val : bus.rt_val;
    assign w_lo_fix = r_neg_q ? -bus.div_q : bus.div_q;
    assign w_hi_fix = r_neg_r ? -bus.div_r : bus.div_r;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div_a <= '0;
            r_div_b <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_go    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start_div) begin
                        r_busy <= 1'b1;
                        if (bus.rt_val != '0) begin
                            r_div_a <= w_mag_a;
                            r_div_b <= w_mag_b;
                            r_neg_q <= w_rs_neg ^ w_rt_neg;
                            r_neg_r <= w_rs_neg;
                            r_go    <= 1'b1;
                            r_state <= S_LAUNCH;
                        end else begin
                            r_zero  <= 1'b1;
                            r_state <= S_ZERO;
                        end
                    end else begin
                        if (bus.hi_wr) r_hi <= bus.wr_data;
                        if (bus.lo_wr) r_lo <= bus.wr_data;
                    end
                end
                S_LAUNCH: begin
                    r_cnt   <= LAT_M1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_go    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_COMMIT;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_COMMIT: begin
                    r_lo    <= w_lo_fix;
                    r_hi    <= w_hi_fix;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_ZERO: begin
                    r_zero  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_go    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_zero  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.div_go   = r_go;
    assign bus.div_a    = r_div_a;
    assign bus.div_b    = r_div_b;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_zero;
    assign bus.hi_out   = r_hi;
    assign bus.lo_out   = r_lo;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed + randomized bench for hilo_div_ctrl with a per-edge divider
// model and an arithmetic reference for the HI/LO results.
module tb_hilo_div_ctrl;

    localparam int LAT = 2;

    logic clk;
    logic reset;

    hilo_div_ctrl_if ifc ();

    hilo_div_ctrl #(.DIV_LAT(LAT)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider captures its operands on each rising edge of div_go
    logic        go_d;
    logic [31:0] q_lat;
    logic [31:0] r_lat;

    always @(posedge clk) begin
        go_d <= ifc.div_go;
        if (ifc.div_go && !go_d) begin
            q_lat <= (ifc.div_b == 0) ? 32'hDEAD_BEEF : ifc.div_a / ifc.div_b;
            r_lat <= (ifc.div_b == 0) ? 32'hDEAD_BEEF : ifc.div_a % ifc.div_b;
        end
    end

    assign ifc.div_q = q_lat;
    assign ifc.div_r = r_lat;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.start_div = 1'b0;
        ifc.is_signed = 1'b0;
        ifc.rs_val    = '0;
        ifc.rt_val    = '0;
        ifc.hi_wr     = 1'b0;
        ifc.lo_wr     = 1'b0;
        ifc.wr_data   = '0;
    endtask

    task automatic noise();
        ifc.start_div = 1'($urandom);
        ifc.is_signed = 1'($urandom);
        ifc.rs_val    = $urandom;
        ifc.rt_val    = $urandom_range(0, 3);
        ifc.hi_wr     = 1'($urandom);
        ifc.lo_wr     = 1'($urandom);
        ifc.wr_data   = $urandom;
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    input bit s, output logic [31:0] q,
                                    output logic [31:0] r);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    task automatic mt(input bit hw, input bit lw, input logic [31:0] d);
        ifc.hi_wr   = hw;
        ifc.lo_wr   = lw;
        ifc.wr_data = d;
        step();
        idle_inputs();
        if (hw) exp_hi = d;
        if (lw) exp_lo = d;
        chk("mt_hi", ifc.hi_out, exp_hi);
        chk("mt_lo", ifc.lo_out, exp_lo);
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle after the op
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          input bit s);
        logic [31:0] eq;
        logic [31:0] er;
        logic [31:0] ea;
        logic [31:0] eb;
        ea = (s && a[31]) ? -a : a;
        eb = (s && b[31]) ? -b : b;
        if (b != 0) ref_div(a, b, s, eq, er);
        ifc.start_div = 1'b1;
        ifc.is_signed = s;
        ifc.rs_val    = a;
        ifc.rt_val    = b;
        ifc.hi_wr     = 1'($urandom);
        ifc.lo_wr     = 1'($urandom);
        ifc.wr_data   = $urandom;
        step();
        if (b == 0) begin
            noise();
            chk("z_busy", 32'(ifc.busy), 1);
            chk("z_flag", 32'(ifc.div_zero), 1);
            chk("z_go", 32'(ifc.div_go), 0);
            chk("z_done", 32'(ifc.done), 0);
            step();
        end else begin
            for (int k = 1; k <= LAT + 2; k++) begin
                noise();
                chk("d_busy", 32'(ifc.busy), 1);
                chk("d_go", 32'(ifc.div_go), 32'(k <= LAT + 1));
                chk("d_done", 32'(ifc.done), 32'(k == LAT + 2));
                chk("d_zero", 32'(ifc.div_zero), 0);
                chk("d_a", ifc.div_a, ea);
                chk("d_b", ifc.div_b, eb);
                chk("d_hold_lo", ifc.lo_out, exp_lo);
                step();
            end
            exp_lo = eq;
            exp_hi = er;
        end
        idle_inputs();
        chk("end_busy", 32'(ifc.busy), 0);
        chk("end_done", 32'(ifc.done), 0);
        chk("end_zero", 32'(ifc.div_zero), 0);
        chk("res_hi", ifc.hi_out, exp_hi);
        chk("res_lo", ifc.lo_out, exp_lo);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int mode;
        idle_inputs();
        exp_hi = '0;
        exp_lo = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_busy", 32'(ifc.busy), 0);
        chk("rst_go", 32'(ifc.div_go), 0);
        chk("rst_done", 32'(ifc.done), 0);
        chk("rst_zero", 32'(ifc.div_zero), 0);
        chk("rst_hi", ifc.hi_out, 0);
        chk("rst_lo", ifc.lo_out, 0);
        chk("rst_a", ifc.div_a, 0);
        chk("rst_b", ifc.div_b, 0);

        do_div(32'd100, 32'd7, 1'b1);
        chk("t100_lo", ifc.lo_out, 32'd14);
        chk("t100_hi", ifc.hi_out, 32'd2);
        do_div(-32'sd7, 32'd2, 1'b1);
        chk("tm7_lo", ifc.lo_out, 32'hFFFF_FFFD);
        chk("tm7_hi", ifc.hi_out, 32'hFFFF_FFFF);
        do_div(-32'sd7, 32'd2, 1'b0);
        chk("tm7u_lo", ifc.lo_out, 32'h7FFF_FFFC);
        chk("tm7u_hi", ifc.hi_out, 32'd1);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        chk("tmin_lo", ifc.lo_out, 32'h8000_0000);
        chk("tmin_hi", ifc.hi_out, 32'd0);

        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        do_div(32'd5, 32'd0, 1'b1);
        chk("z_keep_hi", ifc.hi_out, 32'h11);
        chk("z_keep_lo", ifc.lo_out, 32'h22);
        do_div(32'd9, 32'd4, 1'b0);
        mt(1'b1, 1'b1, 32'hCAFE_F00D);

        // Reset mid-WAIT discards the result
        ifc.start_div = 1'b1;
        ifc.rs_val    = 32'd100;
        ifc.rt_val    = 32'd7;
        step();
        idle_inputs();
        step();
        chk("rw_go", 32'(ifc.div_go), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        chk("rw_busy", 32'(ifc.busy), 0);
        chk("rw_go0", 32'(ifc.div_go), 0);
        chk("rw_hi", ifc.hi_out, 0);
        chk("rw_lo", ifc.lo_out, 0);
        for (int k = 0; k < 6; k++) begin
            chk("rw_nodone", 32'(ifc.done), 0);
            step();
        end

        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            if (mode == 0) begin
                mt(1'($urandom), 1'($urandom), $urandom);
            end else begin
                if (mode == 1) b = '0;
                else if (mode == 2) b = $urandom_range(1, 20);
                else if (mode == 3) b = -$urandom_range(1, 20);
                else if (mode == 4) a = 32'h8000_0000;
                do_div(a, b, 1'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
